// File: rtl/mipi_hs_byte_aligner.sv
// HS byte aligner: hunts the leader sync byte at any of 8 bit offsets, locks, and emits aligned payload.
// Optional macro MIPI_SYNC_ERR_TOLERANT_EN accepts a 1-bit-corrupted sync byte and adds SOT_CORR.
module mipi_hs_byte_aligner #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
    parameter int unsigned SYNC_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       HS_MODE,
    input  logic [7:0] DATA_IN,
    output logic [7:0] BYTE_OUT,
    output logic       BYTE_VALID,
    output logic       SOT,
    output logic       EOT,
    output logic       SOT_ERR,
    output logic [2:0] ALIGN_OFS,
    output logic       LOCKED
`ifdef MIPI_SYNC_ERR_TOLERANT_EN
    ,
    output logic       SOT_CORR
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_WAIT_LP = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(SYNC_TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  data_d_r;
    logic [7:0]  cnt_r;
    logic [15:0] win_s;
    logic [3:0]  exact_s;
    logic        hit_s;
    logic [2:0]  hit_ofs_s;
`ifdef MIPI_SYNC_ERR_TOLERANT_EN
    logic [3:0]  near_s;
    logic        hit_corr_s;
`endif

    // Exact search; iterating downward leaves the lowest matching offset in the result.
    function automatic logic [3:0] find_exact(input logic [15:0] win);
        logic [3:0] res;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            if (win[k +: 8] == SYNC_BYTE) begin
                res = {1'b1, 3'(k)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

`ifdef MIPI_SYNC_ERR_TOLERANT_EN
    // True when exactly one bit of x is set.
    function automatic logic single_bit(input logic [7:0] x);
        return (x != 8'h00) && ((x & (x - 8'h01)) == 8'h00);
    endfunction

    // Hamming-distance-1 search, lowest offset wins.
    function automatic logic [3:0] find_near(input logic [15:0] win);
        logic [3:0] res;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            if (single_bit(win[k +: 8] ^ SYNC_BYTE)) begin
                res = {1'b1, 3'(k)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction
`endif

    assign win_s = {DATA_IN, data_d_r};

    // Sync candidate selection for the current window.
    always_comb begin
        exact_s = find_exact(win_s);
`ifdef MIPI_SYNC_ERR_TOLERANT_EN
        near_s = find_near(win_s);
        if (exact_s[3]) begin
            hit_s      = 1'b1;
            hit_ofs_s  = exact_s[2:0];
            hit_corr_s = 1'b0;
        end else begin
            hit_s      = near_s[3];
            hit_ofs_s  = near_s[2:0];
            hit_corr_s = near_s[3];
        end
`else
        hit_s     = exact_s[3];
        hit_ofs_s = exact_s[2:0];
`endif
    end

    // Alignment FSM with registered outputs; HS_MODE low overrides every state.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r    <= ST_IDLE;
            data_d_r   <= 8'h00;
            cnt_r      <= 8'h00;
            BYTE_OUT   <= 8'h00;
            BYTE_VALID <= 1'b0;
            SOT        <= 1'b0;
            EOT        <= 1'b0;
            SOT_ERR    <= 1'b0;
            ALIGN_OFS  <= 3'd0;
            LOCKED     <= 1'b0;
`ifdef MIPI_SYNC_ERR_TOLERANT_EN
            SOT_CORR   <= 1'b0;
`endif
        end else begin
            data_d_r <= DATA_IN;
            SOT      <= 1'b0;
            EOT      <= 1'b0;
            SOT_ERR  <= 1'b0;
`ifdef MIPI_SYNC_ERR_TOLERANT_EN
            SOT_CORR <= 1'b0;
`endif
            if (!HS_MODE) begin
                state_r    <= ST_IDLE;
                BYTE_VALID <= 1'b0;
                LOCKED     <= 1'b0;
                EOT        <= (state_r == ST_LOCKED);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r    <= ST_HUNT;
                        cnt_r      <= 8'h00;
                        BYTE_VALID <= 1'b0;
                    end
                    ST_HUNT: begin
                        BYTE_VALID <= 1'b0;
                        if (hit_s) begin
                            state_r   <= ST_LOCKED;
                            LOCKED    <= 1'b1;
                            ALIGN_OFS <= hit_ofs_s;
                            SOT       <= 1'b1;
`ifdef MIPI_SYNC_ERR_TOLERANT_EN
                            SOT_CORR  <= hit_corr_s;
`endif
                        end else if (cnt_r == TIMEOUT_LAST) begin
                            state_r <= ST_WAIT_LP;
                            SOT_ERR <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 8'h01;
                        end
                    end
                    ST_LOCKED: begin
                        BYTE_OUT   <= win_s[ALIGN_OFS +: 8];
                        BYTE_VALID <= 1'b1;
                    end
                    ST_WAIT_LP: begin
                        BYTE_VALID <= 1'b0;
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        BYTE_VALID <= 1'b0;
                        LOCKED     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
